// File: rtl/kbd_pkg.sv
// -----------------------------------------------------------------------------
// kbd_pkg
//   Shared definitions for the PS/2 set-2 key decoder:
//     - kbd_state_e : prefix-tracking FSM states
//     - SC_*        : scancode byte constants
//     - is_prefix() : true for the E0 / F0 prefix bytes
// -----------------------------------------------------------------------------
package kbd_pkg;

  // Prefix-tracking states. The FSM remembers which prefix bytes were seen
  // since the last complete scancode.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,  // no prefix pending
    ST_EXT     = 2'd1,  // E0 seen
    ST_BRK     = 2'd2,  // F0 seen
    ST_EXT_BRK = 2'd3   // E0 F0 seen
  } kbd_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;  // extended-key prefix
  localparam logic [7:0] SC_BRK   = 8'hF0;  // break (release) prefix
  localparam logic [7:0] SC_SPACE = 8'h29;  // space bar
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // left arrow (extended)
  localparam logic [7:0] SC_RIGHT = 8'h74;  // right arrow (extended)

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/kbd_key_decoder.sv
// -----------------------------------------------------------------------------
// kbd_key_decoder
//   Decodes a stream of PS/2 set-2 scancode bytes into held-key levels for
//   space, left arrow and right arrow, plus a rising-edge strobe for space and
//   a strobe for illegal prefix sequences (E0/F0 after a pending F0).
//
//   Optional feature (macro KBD_WATCHDOG_EN): a 32-bit idle counter that
//   returns the FSM to IDLE and releases all keys when no byte arrives for
//   TIMEOUT_CYCLES cycles. Without the macro keys stay held until a break.
//
// Parameters
//   TIMEOUT_CYCLES  idle cycles before the watchdog clears (watchdog only)
//
// Ports
//   clk              in   system clock, posedge
//   rst              in   synchronous active-high reset
//   rx_data[7:0]     in   scancode byte
//   rx_valid         in   one-cycle strobe qualifying rx_data
//   key_space        out  level, space held
//   key_left         out  level, left arrow held
//   key_right        out  level, right arrow held
//   key_space_pulse  out  one-cycle strobe when key_space rises
//   proto_err        out  one-cycle strobe on an illegal prefix sequence
//
// Handshake: rx_valid/rx_data is a push-only stream with no back-pressure;
//   every cycle with rx_valid=1 (outside reset) delivers exactly one byte,
//   including on consecutive cycles. All outputs are registered and reflect a
//   byte one clock after the edge that sampled it.
//
// Debug: the FSM state is held in state_q (type kbd_state_e).
// -----------------------------------------------------------------------------
module kbd_key_decoder
  import kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       key_space,
  output logic       key_left,
  output logic       key_right,
  output logic       key_space_pulse,
  output logic       proto_err
);

  kbd_state_e state_q;
  kbd_state_e state_d;

  // Per-byte key actions decoded from the current state and byte.
  logic set_space, clr_space;
  logic set_left,  clr_left;
  logic set_right, clr_right;
  logic err_d;

  // ---------------------------------------------------------------------------
  // Idle watchdog
  // ---------------------------------------------------------------------------
  logic wd_fire;

`ifdef KBD_WATCHDOG_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_cnt_q;

  // A byte arriving in the timeout cycle takes priority: it is decoded and
  // the counter restarts, so the timeout never fires on a valid cycle.
  assign wd_fire = !rx_valid && (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst || rx_valid || wd_fire) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + 32'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || wd_fire) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and per-byte action decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    set_space = 1'b0;
    clr_space = 1'b0;
    set_left  = 1'b0;
    clr_left  = 1'b0;
    set_right = 1'b0;
    clr_right = 1'b0;
    err_d     = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (rx_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (rx_data == SC_BRK) begin
            state_d = ST_BRK;
          end else begin
            // ACK (FA), BAT (AA) and unknown bytes fall through unused.
            set_space = (rx_data == SC_SPACE);
          end
        end

        ST_EXT: begin
          if (rx_data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (rx_data == SC_EXT) begin
            // A repeated E0 keeps the extended prefix pending.
            state_d = ST_EXT;
          end else begin
            state_d   = ST_IDLE;
            set_left  = (rx_data == SC_LEFT);
            set_right = (rx_data == SC_RIGHT);
          end
        end

        ST_BRK: begin
          state_d = ST_IDLE;
          if (is_prefix(rx_data)) begin
            err_d = 1'b1;
          end else begin
            clr_space = (rx_data == SC_SPACE);
          end
        end

        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (is_prefix(rx_data)) begin
            err_d = 1'b1;
          end else begin
            clr_left  = (rx_data == SC_LEFT);
            clr_right = (rx_data == SC_RIGHT);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || wd_fire) begin
      key_space       <= 1'b0;
      key_left        <= 1'b0;
      key_right       <= 1'b0;
      key_space_pulse <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      // At most one action per byte, so set/clear never collide.
      if (set_space) key_space <= 1'b1;
      else if (clr_space) key_space <= 1'b0;

      if (set_left) key_left <= 1'b1;
      else if (clr_left) key_left <= 1'b0;

      if (set_right) key_right <= 1'b1;
      else if (clr_right) key_right <= 1'b0;

      // Typematic repeats arrive while key_space is already high: no strobe.
      key_space_pulse <= set_space && !key_space;
      proto_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_kbd_key_decoder.sv
// -----------------------------------------------------------------------------
// tb_kbd_key_decoder
//   Directed scenarios followed by randomized byte streams, checked every
//   cycle against a reference model that tracks "E0 pending" / "F0 pending"
//   flags and a held-key table. Build with +define+KBD_WATCHDOG_EN to also
//   exercise the idle watchdog (TIMEOUT_CYCLES = 100).
// -----------------------------------------------------------------------------
module tb_kbd_key_decoder;

  localparam int TO = 100;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       key_space, key_left, key_right, key_space_pulse, proto_err;

  always #5 clk = ~clk;

`ifdef KBD_WATCHDOG_EN
  kbd_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
`else
  kbd_key_decoder dut (
`endif
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .key_space       (key_space),
    .key_left        (key_left),
    .key_right       (key_right),
    .key_space_pulse (key_space_pulse),
    .proto_err       (proto_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int obs_pulses;
  int obs_errs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pending-prefix flags + held-key table
  // ---------------------------------------------------------------------------
  bit m_ext, m_brk;
  bit m_keys [3];   // 0 space, 1 left, 2 right
  bit m_pulse, m_err;
  int m_idle;

  function automatic int key_index(input bit ext, input logic [7:0] b);
    if (!ext && b == 8'h29) return 0;
    if (ext && b == 8'h6B) return 1;
    if (ext && b == 8'h74) return 2;
    return -1;
  endfunction

  task automatic model_clear();
    m_ext = 0;
    m_brk = 0;
    for (int i = 0; i < 3; i++) m_keys[i] = 0;
    m_idle = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit r);
    bit was_space;
    int k;
    m_pulse = 0;
    m_err   = 0;
    if (r) begin
      model_clear();
      return;
    end
    if (!v) begin
`ifdef KBD_WATCHDOG_EN
      m_idle++;
      if (m_idle == TO) model_clear();
`endif
      return;
    end
    m_idle    = 0;
    was_space = m_keys[0];
    if (d == 8'hE0 || d == 8'hF0) begin
      if (m_brk) begin
        m_err = 1;
        m_ext = 0;
        m_brk = 0;
      end else if (d == 8'hE0) begin
        m_ext = 1;
      end else begin
        m_brk = 1;
      end
    end else begin
      k = key_index(m_ext, d);
      if (k >= 0) m_keys[k] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
    m_pulse = !was_space && m_keys[0];
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock per call, outputs compared 1 time unit after the edge
  // ---------------------------------------------------------------------------
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    rst      = r;
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(v, d, r);
    #1;
    check("key_space",       32'(key_space),       32'(m_keys[0]));
    check("key_left",        32'(key_left),        32'(m_keys[1]));
    check("key_right",       32'(key_right),       32'(m_keys[2]));
    check("key_space_pulse", 32'(key_space_pulse), 32'(m_pulse));
    check("proto_err",       32'(proto_err),       32'(m_err));
    obs_pulses += int'(key_space_pulse);
    obs_errs   += int'(proto_err);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] pool [8];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'h29, 8'h6B, 8'h74, 8'hFA, 8'hAA, 8'h00};
    obs_pulses = 0;
    obs_errs   = 0;
    model_clear();

    // Reset state, with a byte offered during reset that must be ignored.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h29, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Space make then break.
    obs_pulses = 0;
    send(8'h29);
    check("space_make", 32'(key_space), 32'd1);
    idle(2);
    send(8'hF0);
    send(8'h29);
    check("space_break", 32'(key_space), 32'd0);
    check("space_pulse_count", 32'(obs_pulses), 32'd1);

    // Typematic repeat: one pulse only.
    obs_pulses = 0;
    send(8'h29);
    send(8'h29);
    send(8'h29);
    check("typematic_held", 32'(key_space), 32'd1);
    check("typematic_pulses", 32'(obs_pulses), 32'd1);
    send(8'hF0);
    send(8'h29);

    // Left + right held together, release left only.
    send(8'hE0);
    send(8'h6B);
    send(8'hE0);
    send(8'h74);
    check("both_held", 32'({key_left, key_right}), 32'h3);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    check("left_released", 32'({key_left, key_right}), 32'h1);

    // Illegal F0,E0 sequence, then recovery.
    obs_errs = 0;
    send(8'hF0);
    send(8'hE0);
    check("proto_err_count", 32'(obs_errs), 32'd1);
    check("keys_after_err", 32'({key_space, key_left, key_right}), 32'h1);
    send(8'h29);
    check("space_after_err", 32'(key_space), 32'd1);

    // Reset mid-sequence discards the E0 prefix.
    send(8'hE0);
    step(1'b0, 8'h00, 1'b1);
    send(8'h6B);
    check("reset_drops_prefix", 32'(key_left), 32'd0);

`ifdef KBD_WATCHDOG_EN
    // Timeout after TO idle cycles; a byte in the timeout cycle wins.
    send(8'h29);
    idle(TO - 1);
    check("wd_before_timeout", 32'(key_space), 32'd1);
    idle(1);
    check("wd_timeout", 32'(key_space), 32'd0);
    send(8'h29);
    idle(TO - 1);
    send(8'h29);
    check("wd_valid_wins", 32'(key_space), 32'd1);
    idle(TO);
    check("wd_timeout2", 32'(key_space), 32'd0);
`endif

    // Randomized byte stream, back-to-back and gapped.
    for (int n = 0; n < 4000; n++) begin
      int sel;
      logic [7:0] b;
      sel = int'($urandom_range(0, 7));
      b   = (sel == 7) ? 8'($urandom_range(0, 255)) : pool[sel];
      if ($urandom_range(0, 299) == 0) begin
        step(1'b0, 8'h00, 1'b1);
      end else if ($urandom_range(0, 399) == 0) begin
        idle(int'($urandom_range(TO - 5, TO + 5)));
      end else begin
        step(($urandom_range(0, 9) < 7), b, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
